// File: rtl/delay_pipe.sv
// Enable-gated delay line of p_depth stages with per-stage valid bits and a registered occupancy count.
// Latency: p_depth enabled edges from capture to out_*; stalled edges (en = 0) add one cycle each.
// No backpressure: en = 0 freezes every stage; clear flushes synchronously and wins over en.
module delay_pipe #(
    parameter int                 p_nbits       = 8,
    parameter int                 p_depth       = 4,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           clear,
    input  logic                           in_val,
    input  logic [p_nbits-1:0]             in_data,
    output logic                           out_val,
    output logic [p_nbits-1:0]             out_data,
    output logic [$clog2(p_depth+1)-1:0]   occ
);

    localparam int OW = $clog2(p_depth + 1);

    logic [p_nbits-1:0] data_q [p_depth];
    logic [p_depth-1:0] val_q;
    logic [OW-1:0]      occ_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < p_depth; i++) begin
                data_q[i] <= p_reset_value;
            end
            val_q <= '0;
            occ_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < p_depth; i++) begin
                data_q[i] <= p_reset_value;
            end
            val_q <= '0;
            occ_q <= '0;
        end else if (en) begin
            data_q[0] <= in_data;
            val_q[0]  <= in_val;
            for (int i = 1; i < p_depth; i++) begin
                data_q[i] <= data_q[i-1];
                val_q[i]  <= val_q[i-1];
            end
            // Modular add/subtract is safe: the true result always lies in 0..p_depth.
            occ_q <= occ_q + OW'(in_val) - OW'(val_q[p_depth-1]);
        end
    end

    assign out_val  = val_q[p_depth-1];
    assign out_data = data_q[p_depth-1];
    assign occ      = occ_q;

endmodule
